// File: rtl/laser_cover_scan_pkg.sv
// Shared types and the radius hit test for the two-circle cover engine.
package laser_cover_scan_pkg;

    typedef enum logic [1:0] {StLoad, StScan, StUpdate, StFin} state_e;

    // Widest coordinate the hit test supports; narrower grids zero-extend into it.
    localparam int unsigned MaxCoordW = 8;

    typedef logic [MaxCoordW-1:0] coord_t;
    typedef logic [2*MaxCoordW:0] sq_t;

    function automatic logic covered(input coord_t px, input coord_t py,
                                     input coord_t cx, input coord_t cy,
                                     input int unsigned radius);
        sq_t dx;
        sq_t dy;
        sq_t d2;
        dx = (px >= cx) ? sq_t'(px - cx) : sq_t'(cx - px);
        dy = (py >= cy) ? sq_t'(py - cy) : sq_t'(cy - py);
        d2 = dx * dx + dy * dy;
        return {15'd0, d2} <= radius * radius;
    endfunction

endpackage

// File: rtl/laser_cover_scan_hit_lanes.sv
// One slice of parallel hit tests against a candidate centre, plus the count of hits
// that are not already claimed by the fixed circle.
module laser_cover_scan_hit_lanes
    import laser_cover_scan_pkg::*;
#(
    parameter int unsigned COORD_W = 4,
    parameter int unsigned LANES   = 10,
    parameter int unsigned RADIUS  = 4
) (
    input  logic [LANES-1:0][COORD_W-1:0] px_i,
    input  logic [LANES-1:0][COORD_W-1:0] py_i,
    input  logic [COORD_W-1:0]            cx_i,
    input  logic [COORD_W-1:0]            cy_i,
    input  logic [LANES-1:0]              fixed_i,
    output logic [LANES-1:0]              hit_o,
    output logic [$clog2(LANES+1)-1:0]    cnt_o
);

    logic [LANES-1:0] hit;

    always_comb begin
        hit   = '0;
        cnt_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            hit[i] = covered(coord_t'(px_i[i]), coord_t'(py_i[i]),
                             coord_t'(cx_i), coord_t'(cy_i), RADIUS);
            if (hit[i] && !fixed_i[i]) begin
                cnt_o = cnt_o + 1'b1;
            end
        end
    end

    assign hit_o = hit;

endmodule

// File: rtl/laser_cover_scan.sv
// Two-circle point-cover engine: loads N_PTS points, then alternately re-places circles A/B by
// exhaustive grid scan. Optional SCORE output enabled by defining LASER_COVER_SCORE_EN.
module laser_cover_scan
    import laser_cover_scan_pkg::*;
#(
    parameter int unsigned COORD_W  = 4,
    parameter int unsigned N_PTS    = 40,
    parameter int unsigned LANES    = 10,
    parameter int unsigned RADIUS   = 4,
    parameter int unsigned MAX_ITER = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [COORD_W-1:0]           x_i,
    input  logic [COORD_W-1:0]           y_i,
    output logic [COORD_W-1:0]           c1x_o,
    output logic [COORD_W-1:0]           c1y_o,
    output logic [COORD_W-1:0]           c2x_o,
    output logic [COORD_W-1:0]           c2y_o,
`ifdef LASER_COVER_SCORE_EN
    output logic [$clog2(N_PTS+1)-1:0]   score_o,
`endif
    output logic                         done_o
);

    localparam int unsigned NSlices  = N_PTS / LANES;
    localparam int unsigned SliceW   = (NSlices > 1) ? $clog2(NSlices) : 1;
    localparam int unsigned CandW    = 2 * COORD_W;
    localparam int unsigned CntW     = $clog2(N_PTS + 1);
    localparam int unsigned LaneCntW = $clog2(LANES + 1);
    localparam int unsigned RoundW   = $clog2(MAX_ITER + 1);

    state_e                         state_q;
    logic [N_PTS-1:0][COORD_W-1:0]  pts_x_q, pts_y_q;
    logic [CntW-1:0]                pt_cnt_q;
    logic [CandW-1:0]               cand_q;
    logic [SliceW-1:0]              slice_q;
    logic [CntW-1:0]                acc_q, best_q;
    logic [CandW-1:0]               best_c_q, fixed_c_q, prev_c_q;
    logic                           prev_valid_q;
    logic [N_PTS-1:0]               best_mask_q, fixed_mask_q, cand_mask_q;
    logic [RoundW-1:0]              round_q;
    logic [CandW-1:0]               c1_q, c2_q;
    logic                           in_ready_q, done_q;

    logic [LANES-1:0][COORD_W-1:0]  lane_x, lane_y;
    logic [LANES-1:0]               lane_fixed, lane_hit;
    logic [LaneCntW-1:0]            lane_cnt;
    logic [N_PTS-1:0]               cand_mask_full;
    logic [CntW-1:0]                cand_total;
    logic [RoundW-1:0]              round_inc;
    logic                           last_slice, finish;

    assign lane_x     = pts_x_q[slice_q*LANES +: LANES];
    assign lane_y     = pts_y_q[slice_q*LANES +: LANES];
    assign lane_fixed = fixed_mask_q[slice_q*LANES +: LANES];

    laser_cover_scan_hit_lanes #(
        .COORD_W (COORD_W),
        .LANES   (LANES),
        .RADIUS  (RADIUS)
    ) u_hit_lanes (
        .px_i    (lane_x),
        .py_i    (lane_y),
        .cx_i    (cand_q[COORD_W-1:0]),
        .cy_i    (cand_q[CandW-1:COORD_W]),
        .fixed_i (lane_fixed),
        .hit_o   (lane_hit),
        .cnt_o   (lane_cnt)
    );

    // Cover mask of the current candidate including the slice being tested this cycle.
    always_comb begin
        cand_mask_full = cand_mask_q;
        cand_mask_full[slice_q*LANES +: LANES] = lane_hit;
    end

    assign cand_total = acc_q + CntW'(lane_cnt);
    assign last_slice = (slice_q == SliceW'(NSlices - 1));
    assign round_inc  = round_q + 1'b1;
    assign finish     = (prev_valid_q && (best_c_q == prev_c_q)) ||
                        (round_inc == RoundW'(MAX_ITER));

`ifdef LASER_COVER_SCORE_EN
    logic [CntW-1:0]  union_cnt, score_q;
    logic [N_PTS-1:0] union_mask;

    always_comb begin
        union_mask = best_mask_q | fixed_mask_q;
        union_cnt  = '0;
        for (int unsigned i = 0; i < N_PTS; i++) begin
            if (union_mask[i]) begin
                union_cnt = union_cnt + 1'b1;
            end
        end
    end

    assign score_o = score_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StLoad;
            pts_x_q      <= '0;
            pts_y_q      <= '0;
            pt_cnt_q     <= '0;
            cand_q       <= '0;
            slice_q      <= '0;
            acc_q        <= '0;
            best_q       <= '0;
            best_c_q     <= '0;
            fixed_c_q    <= '0;
            prev_c_q     <= '0;
            prev_valid_q <= 1'b0;
            best_mask_q  <= '0;
            fixed_mask_q <= '0;
            cand_mask_q  <= '0;
            round_q      <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            in_ready_q   <= 1'b1;
            done_q       <= 1'b0;
`ifdef LASER_COVER_SCORE_EN
            score_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    if (in_valid_i) begin
                        pts_x_q[pt_cnt_q] <= x_i;
                        pts_y_q[pt_cnt_q] <= y_i;
                        if (pt_cnt_q == CntW'(N_PTS - 1)) begin
                            pt_cnt_q   <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= StScan;
                        end else begin
                            pt_cnt_q <= pt_cnt_q + 1'b1;
                        end
                    end
                end
                StScan: begin
                    cand_mask_q <= cand_mask_full;
                    if (last_slice) begin
                        acc_q   <= '0;
                        slice_q <= '0;
                        // >= makes the last candidate in scan order win ties.
                        if (cand_total >= best_q) begin
                            best_q      <= cand_total;
                            best_c_q    <= cand_q;
                            best_mask_q <= cand_mask_full;
                        end
                        cand_q <= cand_q + 1'b1;
                        if (&cand_q) begin
                            state_q <= StUpdate;
                        end
                    end else begin
                        acc_q   <= cand_total;
                        slice_q <= slice_q + 1'b1;
                    end
                end
                StUpdate: begin
                    round_q <= round_inc;
                    c1_q    <= best_c_q;
                    c2_q    <= fixed_c_q;
`ifdef LASER_COVER_SCORE_EN
                    score_q <= union_cnt;
`endif
                    if (finish) begin
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        fixed_c_q    <= best_c_q;
                        fixed_mask_q <= best_mask_q;
                        prev_c_q     <= fixed_c_q;
                        prev_valid_q <= 1'b1;
                        best_q       <= '0;
                        best_mask_q  <= '0;
                        state_q      <= StScan;
                    end
                end
                StFin: begin
                    round_q      <= '0;
                    best_q       <= '0;
                    best_c_q     <= '0;
                    best_mask_q  <= '0;
                    fixed_mask_q <= '0;
                    fixed_c_q    <= '0;
                    prev_c_q     <= '0;
                    prev_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                    state_q      <= StLoad;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign done_o     = done_q;
    assign c1x_o      = c1_q[COORD_W-1:0];
    assign c1y_o      = c1_q[CandW-1:COORD_W];
    assign c2x_o      = c2_q[COORD_W-1:0];
    assign c2y_o      = c2_q[CandW-1:COORD_W];

endmodule
